clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 3, the number of divided clock channels (0=soc, 1=per, 2=cluster).
REQ-002 Parameter DIV_W, default 8, the width of each channel's divider field.
REQ-003 Parameter DIV_RST, default 1, the divider value loaded at reset in every channel.
REQ-004 Parameter LOCK_CYC, default 4, the number of output rising edges after a settle before lock asserts.
REQ-005 ref_clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-006 rstn_glob_i  in  1  the reset, asynchronous and active-low.
REQ-007 clk_o  out  NUM_CH  divided clocks, one per channel.
REQ-008 cfg_req_i  in  NUM_CH  per-channel config request.
REQ-009 cfg_ack_o  out  NUM_CH  per-channel config acknowledge.
REQ-010 cfg_add_i  in  NUM_CH x 2  per-channel register address.
REQ-011 cfg_wrn_i  in  NUM_CH  per-channel access type: 1=read, 0=write.
REQ-012 cfg_data_i  in  NUM_CH x 32  per-channel write data.
REQ-013 cfg_r_data_o  out  NUM_CH x 32  per-channel read data.
REQ-014 cfg_lock_o  out  NUM_CH  per-channel lock indicator.

Function
REQ-015 Register map: addr 0 DIV[DIV_W-1:0] (RW); addr 1 CTRL bit0 EN (RW); addr 2 STATUS {pending, en, lock} in bits [2:0] (RO); addr 3 ID = 0x000C_0000 | (channel index << 8) | NUM_CH (RO).
REQ-016 Handshake: a rising edge on cfg_req_i is detected on the clock edge where req=1 and the previous sample was 0; cfg_ack_o pulses high for exactly 1 cycle, on the cycle after detection.
REQ-017 A request held high produces exactly one ack; the next ack needs req low for at least one cycle first.
REQ-018 On a read, cfg_r_data_o is registered and valid in the same cycle as the ack; it holds until the next read ack.
REQ-019 Writes to addresses 2 and 3 are acked and have no effect.
REQ-020 Divider: while EN=1, clk_o toggles every D ref_clk cycles, giving a period of 2*D cycles with 50% duty; D = DIV, with DIV=0 treated as 1.
REQ-021 A DIV write sets pending=1 and drops lock in the cycle of the ack; the new D takes effect only at the next falling transition of clk_o (glitch-free), and pending then clears.
REQ-022 A second DIV write while pending=1 replaces the pending value; only the last one is applied.
REQ-023 EN 1->0 takes effect at the next falling transition of clk_o; the output then stays 0 and lock is 0.
REQ-024 EN 0->1 starts the first high phase on the next cycle.
REQ-025 Lock counter: it restarts on every DIV apply and every enable, and counts clk_o rising edges; cfg_lock_o asserts once the count reaches LOCK_CYC and then saturates.
REQ-026 The bank can issue simultaneous requests on different channels; channels are fully independent.

Reset
REQ-027 Asynchronous assertion of rstn_glob_i forces, with no clock edge: clk_o=0, cfg_ack_o=0, cfg_r_data_o=0, cfg_lock_o=0, pending=0, DIV=DIV_RST, EN=1, and lock count 0.
REQ-028 After reset deasserts, clk_o starts toggling on the first clock edge.
REQ-029 A reset in the middle of a transaction aborts it with no ack, and the request must be re-issued.

Structure
REQ-030 Package clk_div_pkg holds the register address constants, the STATUS bit positions, and the ID base 0x000C_0000.
REQ-031 Sub-module clk_div_ch implements one channel: the register file, handshake, divider and lock; clk_div_bank instantiates NUM_CH copies in a generate loop.

Verification
REQ-032 After reset with DIV_RST=1: clk_o[0] has a period of 2 cycles, and lock rises after 4 rising edges of clk_o[0].
REQ-033 Write DIV=5 on channel 1 -> one ack pulse; lock drops the same cycle; the period becomes 10 after the next falling edge, with no pulse shorter than 1 cycle; lock returns after 4 edges.
REQ-034 Read addr 3 on channel 2 with NUM_CH=3 -> r_data=0x000C_0203 with the ack.
REQ-035 Write EN=0 while clk_o is high -> the output falls at the phase end and then stays 0; STATUS reads 0b000.
REQ-036 Write DIV=3 then DIV=7 within one output phase -> only 7 is applied, so the period is 14.
REQ-037 Assert reset during a held req with DIV=9 -> all outputs 0 immediately; after release DIV reads 1 and no ack is issued until req toggles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank: register map, STATUS layout,
// ID encoding and the per-channel divider phase encoding.
package clk_div_pkg;

  localparam logic [1:0] ADDR_DIV    = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_ID     = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int STAT_LOCK = 0;
  localparam int STAT_EN   = 1;
  localparam int STAT_PEND = 2;

  localparam logic [31:0] ID_BASE = 32'h000C_0000;

  // Encoding keeps clk_o a single AND of two flops whose transitions are monotonic.
  typedef enum logic [1:0] {
    DIV_OFF  = 2'b00,
    DIV_LOW  = 2'b10,
    DIV_HIGH = 2'b11
  } div_state_e;

  function automatic logic [31:0] make_id(input int ch, input int num_ch);
    return ID_BASE | (32'(ch) << 8) | 32'(num_ch);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: config registers with req/ack handshake,
// glitch-free 50% divider and lock counter.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CH_IDX   = 0,
  parameter int NUM_CH   = 3,
  parameter int DIV_W    = 8,
  parameter int DIV_RST  = 1,
  parameter int LOCK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [1:0]  add,
  input  logic        wrn,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        clk_out,
  output logic        lock
);

  localparam int              LW       = $clog2(LOCK_CYC + 1);
  localparam logic [LW-1:0]   LOCK_MAX = LW'(LOCK_CYC);

  logic             req_q;
  logic             ack_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_val;
  logic [DIV_W-1:0] div_reg_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] d_eff;
  logic [DIV_W-1:0] cnt_q;
  logic             en_q;
  logic             pend_q;
  logic [LW-1:0]    lock_cnt_q;
  div_state_e       state_q;
  div_state_e       state_d;

  logic req_rise;
  logic wr;
  logic rd;
  logic phase_end;
  logic rise;
  logic fall;
  logic apply;
  logic wdata_unused;

  assign wdata_unused = &{1'b0, wdata};

  assign req_rise  = req & ~req_q;
  assign wr        = req_rise & ~wrn;
  assign rd        = req_rise & wrn;
  assign d_eff     = (div_q == '0) ? DIV_W'(1) : div_q;
  assign phase_end = (cnt_q >= (d_eff - DIV_W'(1)));

  // Divider phase: state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      state_q <= DIV_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider phase: next-state logic
  always_comb begin
    // NOTE: default assignment first, so no branch can leave state_d unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      DIV_OFF:  if (en_q) state_d = DIV_HIGH;
      DIV_HIGH: if (phase_end) state_d = en_q ? DIV_LOW : DIV_OFF;
      DIV_LOW: begin
        if (!en_q)          state_d = DIV_OFF;
        else if (phase_end) state_d = DIV_HIGH;
      end
      default:  state_d = DIV_OFF;
    endcase
  end

  // Divider phase: outputs and edge events
  always_comb begin
    clk_out = (state_q == DIV_HIGH);
    rise    = (state_d == DIV_HIGH) && (state_q != DIV_HIGH);
    fall    = (state_q == DIV_HIGH) && (state_d != DIV_HIGH);
    // A new divider is only swapped in at a falling edge or while stopped.
    apply   = pend_q && (fall || (state_q == DIV_OFF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= DIV_W'(DIV_RST);
      lock_cnt_q <= '0;
    end else begin
      if ((state_d != state_q) || (state_d == DIV_OFF)) cnt_q <= '0;
      else                                               cnt_q <= cnt_q + DIV_W'(1);

      if (apply) div_q <= div_reg_q;

      if (state_d == DIV_OFF)                  lock_cnt_q <= '0;
      else if (apply)                          lock_cnt_q <= rise ? LW'(1) : '0;
      else if (rise && lock_cnt_q != LOCK_MAX) lock_cnt_q <= lock_cnt_q + LW'(1);
    end
  end

  assign lock = (lock_cnt_q == LOCK_MAX) && !pend_q;

  always_comb begin
    rd_val = '0;
    unique case (add)
      ADDR_DIV:    rd_val[DIV_W-1:0] = div_reg_q;
      ADDR_CTRL:   rd_val[CTRL_EN]   = en_q;
      ADDR_STATUS: begin
        rd_val[STAT_PEND] = pend_q;
        rd_val[STAT_EN]   = en_q;
        rd_val[STAT_LOCK] = lock;
      end
      ADDR_ID:     rd_val = make_id(CH_IDX, NUM_CH);
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset to 1 so a request held across reset is not taken as a new edge.
      req_q     <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      div_reg_q <= DIV_W'(DIV_RST);
      en_q      <= 1'b1;
      pend_q    <= 1'b0;
    end else begin
      req_q <= req;
      ack_q <= req_rise;
      if (apply) pend_q <= 1'b0;
      if (wr) begin
        unique case (add)
          ADDR_DIV: begin
            div_reg_q <= wdata[DIV_W-1:0];
            pend_q    <= 1'b1;
          end
          ADDR_CTRL: en_q <= wdata[CTRL_EN];
          default: ;
        endcase
      end
      if (rd) rdata_q <= rd_val;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent divided-clock channels sharing one reference clock
// and reset; each channel has its own config port.
module clk_div_bank #(
  parameter int NUM_CH   = 3,
  parameter int DIV_W    = 8,
  parameter int DIV_RST  = 1,
  parameter int LOCK_CYC = 4
) (
  input  logic                  ref_clk_i,
  input  logic                  rstn_glob_i,
  output logic [NUM_CH-1:0]     clk_o,
  input  logic [NUM_CH-1:0]     cfg_req_i,
  output logic [NUM_CH-1:0]     cfg_ack_o,
  input  logic [2*NUM_CH-1:0]   cfg_add_i,
  input  logic [NUM_CH-1:0]     cfg_wrn_i,
  input  logic [32*NUM_CH-1:0]  cfg_data_i,
  output logic [32*NUM_CH-1:0]  cfg_r_data_o,
  output logic [NUM_CH-1:0]     cfg_lock_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CH_IDX   (g),
      .NUM_CH   (NUM_CH),
      .DIV_W    (DIV_W),
      .DIV_RST  (DIV_RST),
      .LOCK_CYC (LOCK_CYC)
    ) u_ch (
      .clk     (ref_clk_i),
      .rst_n   (rstn_glob_i),
      .req     (cfg_req_i[g]),
      .add     (cfg_add_i[2*g +: 2]),
      .wrn     (cfg_wrn_i[g]),
      .wdata   (cfg_data_i[32*g +: 32]),
      .ack     (cfg_ack_o[g]),
      .rdata   (cfg_r_data_o[32*g +: 32]),
      .clk_out (clk_o[g]),
      .lock    (cfg_lock_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: reset, handshake, divider periods, pending
// divider replacement, enable control, lock timing and reset mid-transaction.
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int BUDGET = 200;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_CH-1:0]    clk_o;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    ack;
  logic [2*NUM_CH-1:0]  add;
  logic [NUM_CH-1:0]    wrn;
  logic [32*NUM_CH-1:0] wdata;
  logic [32*NUM_CH-1:0] rdata;
  logic [NUM_CH-1:0]    lock;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (8),
    .DIV_RST  (1),
    .LOCK_CYC (4)
  ) dut (
    .ref_clk_i    (clk),
    .rstn_glob_i  (rst_n),
    .clk_o        (clk_o),
    .cfg_req_i    (req),
    .cfg_ack_o    (ack),
    .cfg_add_i    (add),
    .cfg_wrn_i    (wrn),
    .cfg_data_i   (wdata),
    .cfg_r_data_o (rdata),
    .cfg_lock_o   (lock)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction on channel ch, starting and ending on a falling clock edge.
  task automatic xfer(input int ch, input logic wr_n, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic ck, output logic lk);
    add[2*ch +: 2]    = a;
    wrn[ch]           = wr_n;
    wdata[32*ch +: 32] = d;
    req[ch]           = 1'b1;
    @(negedge clk);
    check($sformatf("ack_pulse_ch%0d", ch), {31'b0, ack[ch]}, 32'd1);
    rd = rdata[32*ch +: 32];
    ck = clk_o[ch];
    lk = lock[ch];
    req[ch] = 1'b0;
    @(negedge clk);
    check($sformatf("ack_single_ch%0d", ch), {31'b0, ack[ch]}, 32'd0);
  endtask

  task automatic measure(input int ch, output int high, output int period);
    int n = 0;
    high = 0;
    period = 0;
    while (clk_o[ch] !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
    while (clk_o[ch] !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    while (clk_o[ch] === 1'b1 && n < BUDGET) begin high++; period++; @(negedge clk); n++; end
    while (clk_o[ch] === 1'b0 && n < BUDGET) begin period++; @(negedge clk); n++; end
    if (n >= BUDGET) begin high = 0; period = 0; end
  endtask

  task automatic wait_rise(input int ch);
    int n = 0;
    while (clk_o[ch] !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
    while (clk_o[ch] !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    check($sformatf("rise_seen_ch%0d", ch), {31'b0, n < BUDGET}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        ck;
    logic        lk;
    logic        prev;
    int          h;
    int          p;
    int          cyc;
    int          r;
    int          acks;

    req   = '0;
    wrn   = '0;
    add   = '0;
    wdata = '0;

    // Asynchronous reset with no clock edge in between
    #1 rst_n = 1'b0;
    #1;
    check("rst_clk_o", {29'b0, clk_o}, 32'd0);
    check("rst_ack", {29'b0, ack}, 32'd0);
    check("rst_lock", {29'b0, lock}, 32'd0);
    check("rst_rdata", {31'b0, |rdata}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // First edge starts the output; lock after 4 rising edges at D=1
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("first_edge_clk_o", {29'b0, clk_o}, 32'h7);
    end while (!lock[0] && cyc < BUDGET);
    check("lock_after_reset_cycles", cyc, 32'd7);
    check("lock_all_channels", {29'b0, lock}, 32'h7);
    measure(0, h, p);
    check("ch0_period_d1", p, 32'd2);
    check("ch0_high_d1", h, 32'd1);

    // Simultaneous ID reads on all channels
    add = {2'd3, 2'd3, 2'd3};
    wrn = 3'b111;
    req = 3'b111;
    @(negedge clk);
    check("multi_ack", {29'b0, ack}, 32'h7);
    check("id_ch0", rdata[31:0], 32'h000C_0003);
    check("id_ch1", rdata[63:32], 32'h000C_0103);
    check("id_ch2", rdata[95:64], 32'h000C_0203);
    req = 3'b000;
    @(negedge clk);
    check("multi_ack_low", {29'b0, ack}, 32'h0);

    // DIV=5 on channel 1
    check("ch1_locked_before", {31'b0, lock[1]}, 32'd1);
    xfer(1, 1'b0, 2'd0, 32'd5, rd, ck, lk);
    check("ch1_lock_drop_at_ack", {31'b0, lk}, 32'd0);
    repeat (3) @(negedge clk);
    measure(1, h, p);
    check("ch1_period_d5", p, 32'd10);
    check("ch1_high_d5", h, 32'd5);
    check("ch1_unlocked_2_edges", {31'b0, lock[1]}, 32'd0);
    r = 0;
    cyc = 0;
    prev = clk_o[1];
    while (!lock[1] && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (clk_o[1] && !prev) r++;
      prev = clk_o[1];
    end
    check("ch1_relock_rises", r, 32'd2);
    xfer(1, 1'b1, 2'd0, 32'd0, rd, ck, lk);
    check("ch1_div_read", rd, 32'd5);
    xfer(1, 1'b1, 2'd2, 32'd0, rd, ck, lk);
    check("ch1_status_locked", rd, 32'b011);

    // DIV=0 behaves as 1
    xfer(0, 1'b0, 2'd0, 32'd0, rd, ck, lk);
    repeat (3) @(negedge clk);
    measure(0, h, p);
    check("ch0_period_d0", p, 32'd2);

    // EN=0 while high on channel 2 (D=8)
    xfer(2, 1'b0, 2'd0, 32'd8, rd, ck, lk);
    repeat (3) @(negedge clk);
    wait_rise(2);
    xfer(2, 1'b0, 2'd1, 32'd0, rd, ck, lk);
    check("ch2_high_at_en_off", {31'b0, ck}, 32'd1);
    h = 0;
    while (clk_o[2] === 1'b1 && h < BUDGET) begin h++; @(negedge clk); end
    check("ch2_rest_of_phase", h, 32'd6);
    h = 0;
    repeat (20) begin @(negedge clk); if (clk_o[2] !== 1'b0) h++; end
    check("ch2_stays_low", h, 32'd0);
    xfer(2, 1'b1, 2'd2, 32'd0, rd, ck, lk);
    check("ch2_status_off", rd, 32'b000);
    check("ch2_lock_off", {31'b0, lock[2]}, 32'd0);

    // EN=1, then DIV=3 and DIV=7 within the first high phase
    xfer(2, 1'b0, 2'd1, 32'd1, rd, ck, lk);
    check("ch2_low_at_en_ack", {31'b0, ck}, 32'd0);
    check("ch2_high_next_cycle", {31'b0, clk_o[2]}, 32'd1);
    xfer(2, 1'b0, 2'd0, 32'd3, rd, ck, lk);
    xfer(2, 1'b0, 2'd0, 32'd7, rd, ck, lk);
    check("ch2_same_phase", {31'b0, clk_o[2]}, 32'd1);
    repeat (10) @(negedge clk);
    measure(2, h, p);
    check("ch2_period_d7", p, 32'd14);
    check("ch2_high_d7", h, 32'd7);
    xfer(2, 1'b1, 2'd0, 32'd0, rd, ck, lk);
    check("ch2_div_read", rd, 32'd7);

    // A held request is acknowledged once
    add[3:2] = 2'd1;
    wrn[1]   = 1'b1;
    req[1]   = 1'b1;
    acks = 0;
    repeat (6) begin @(negedge clk); if (ack[1]) acks++; end
    check("held_req_one_ack", acks, 32'd1);
    check("held_req_rdata", rdata[63:32], 32'd1);
    req[1] = 1'b0;
    @(negedge clk);
    xfer(1, 1'b1, 2'd1, 32'd0, rd, ck, lk);
    check("reissued_req_rdata", rd, 32'd1);

    // Reset during a held request with DIV=9
    xfer(0, 1'b0, 2'd0, 32'd9, rd, ck, lk);
    wait_rise(1);
    add[1:0] = 2'd0;
    wrn[0]   = 1'b1;
    req[0]   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_clk_o", {29'b0, clk_o}, 32'd0);
    check("mid_rst_ack", {29'b0, ack}, 32'd0);
    check("mid_rst_lock", {29'b0, lock}, 32'd0);
    check("mid_rst_rdata", {31'b0, |rdata}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    acks = 0;
    repeat (5) begin @(negedge clk); if (ack[0]) acks++; end
    check("no_ack_after_rst", acks, 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    xfer(0, 1'b1, 2'd0, 32'd0, rd, ck, lk);
    check("div_after_rst", rd, 32'd1);
    measure(0, h, p);
    check("ch0_period_after_rst", p, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
